// File: rtl/aurora_pkg.sv
// Shared constants for the Aurora TX datapath.
package aurora_pkg;
  localparam int unsigned AXI_DATA_SIZE = 64;
endpackage

// File: rtl/tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding the Aurora TX data controller from
// two AXI-stream sources, pacing beats to the lane rate and gapping frames.
module tx_frame_arbiter
  import aurora_pkg::*;
#(
  parameter int unsigned DATA_W    = AXI_DATA_SIZE,
  parameter int unsigned FRAME_GAP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              single_lane,
  input  logic              s0_valid,
  input  logic              s1_valid,
  input  logic              s0_last,
  input  logic              s1_last,
  input  logic [DATA_W-1:0] s0_data,
  input  logic [DATA_W-1:0] s1_data,
  output logic              s0_ready,
  output logic              s1_ready,
  output logic              m_valid,
  output logic              m_last,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int unsigned GAP_W = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, GAP} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic              lane_single, lane_nxt;
  logic              rr_ptr, rr_nxt;
  logic [1:0]        grant_nxt;
  logic              m_valid_nxt, m_last_nxt;
  logic [DATA_W-1:0] m_data_nxt;
  logic              own_valid, own_last;
  logic [DATA_W-1:0] own_data;
  logic              hold_done;

  assign own_valid = grant[0] ? s0_valid : s1_valid;
  assign own_last  = grant[0] ? s0_last  : s1_last;
  assign own_data  = grant[0] ? s0_data  : s1_data;
  assign hold_done = (cnt == (lane_single ? 3'd6 : 3'd0));

  assign s0_ready = (state == LOAD) && grant[0];
  assign s1_ready = (state == LOAD) && grant[1];
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    rr_nxt      = rr_ptr;
    cnt_nxt     = cnt;
    gap_nxt     = gap_cnt;
    lane_nxt    = lane_single;
    m_valid_nxt = m_valid;
    m_last_nxt  = m_last;
    m_data_nxt  = m_data;
    case (state)
      IDLE: begin
        m_valid_nxt = 1'b0;
        m_last_nxt  = 1'b0;
        m_data_nxt  = '0;
        grant_nxt   = 2'b00;
        if (s0_valid || s1_valid) begin
          grant_nxt = (s0_valid && (!s1_valid || !rr_ptr)) ? 2'b01 : 2'b10;
          lane_nxt  = single_lane;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        m_valid_nxt = own_valid;
        m_last_nxt  = own_valid && own_last;
        m_data_nxt  = own_valid ? own_data : '0;
        cnt_nxt     = '0;
        state_nxt   = HOLD;
      end
      HOLD: begin
        if (hold_done) begin
          gap_nxt   = '0;
          state_nxt = (m_valid && m_last) ? GAP : LOAD;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      GAP: begin
        // The first GAP cycle is still the final cycle of the last beat, so the
        // outputs clear at its edge and FRAME_GAP idle cycles follow.
        if (gap_cnt == '0) begin
          m_valid_nxt = 1'b0;
          m_last_nxt  = 1'b0;
          m_data_nxt  = '0;
          grant_nxt   = 2'b00;
          rr_nxt      = grant[0];
        end
        if (gap_cnt == GAP_W'(FRAME_GAP)) begin
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      gap_cnt     <= '0;
      lane_single <= 1'b0;
      rr_ptr      <= 1'b0;
      grant       <= 2'b00;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_data      <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      gap_cnt     <= gap_nxt;
      lane_single <= lane_nxt;
      rr_ptr      <= rr_nxt;
      grant       <= grant_nxt;
      m_valid     <= m_valid_nxt;
      m_last      <= m_last_nxt;
      m_data      <= m_data_nxt;
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: two instances (FRAME_GAP 4 and 0), queue-based
// sources and a schedule model that predicts every output cycle.
module tb_tx_frame_arbiter;
  localparam int unsigned W = 64;

  typedef struct packed {
    logic         bub;
    logic         last;
    logic [W-1:0] data;
  } beat_t;

  typedef struct packed {
    logic         v;
    logic         l;
    logic [W-1:0] d;
    logic [1:0]   g;
    logic [1:0]   r;
    logic         b;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         single_lane = 1'b0;
  int           sel = 0;
  logic [1:0]   vld = '0;
  logic [1:0]   lst = '0;
  logic [W-1:0] dat [2];

  wire  [1:0]   s0_v, s1_v, s0_l, s1_l, r0_o, r1_o, mv_o, ml_o, b_o;
  wire  [W-1:0] s0_d [2];
  wire  [W-1:0] s1_d [2];
  wire  [W-1:0] md_o [2];
  wire  [1:0]   g_o  [2];

  int           total = 0;
  int           bad = 0;
  int           vcnt = 0;
  beat_t        src0_q[$], src1_q[$], mdl0_q[$], mdl1_q[$];
  obs_t         exp_q[$];
  logic [1:0]   gseq[$];
  logic [1:0]   rr_m = '0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    assign s0_v[k] = (sel == k) && vld[0];
    assign s1_v[k] = (sel == k) && vld[1];
    assign s0_l[k] = (sel == k) && lst[0];
    assign s1_l[k] = (sel == k) && lst[1];
    assign s0_d[k] = (sel == k) ? dat[0] : '0;
    assign s1_d[k] = (sel == k) ? dat[1] : '0;
    tx_frame_arbiter #(.DATA_W(W), .FRAME_GAP(k == 0 ? 4 : 0)) u_dut (
      .clk(clk), .rst_n(rst_n), .single_lane(single_lane),
      .s0_valid(s0_v[k]), .s1_valid(s1_v[k]),
      .s0_last(s0_l[k]), .s1_last(s1_l[k]),
      .s0_data(s0_d[k]), .s1_data(s1_d[k]),
      .s0_ready(r0_o[k]), .s1_ready(r1_o[k]),
      .m_valid(mv_o[k]), .m_last(ml_o[k]), .m_data(md_o[k]),
      .grant(g_o[k]), .busy(b_o[k])
    );
  end

  function automatic obs_t sample();
    obs_t o;
    o.v = mv_o[sel];
    o.l = ml_o[sel];
    o.d = md_o[sel];
    o.g = g_o[sel];
    o.r = {r1_o[sel], r0_o[sel]};
    o.b = b_o[sel];
    return o;
  endfunction

  task automatic add_frame(input int s, input int n, input logic [W-1:0] base,
                           input int bub_at, input bit rnd);
    beat_t bt;
    for (int i = 0; i < n; i++) begin
      if (i == bub_at) begin
        bt = '0;
        bt.bub = 1'b1;
        if (s == 0) begin src0_q.push_back(bt); mdl0_q.push_back(bt); end
        else        begin src1_q.push_back(bt); mdl1_q.push_back(bt); end
      end
      bt.bub  = 1'b0;
      bt.last = (i == n - 1);
      bt.data = rnd ? {$urandom, $urandom} : base + W'(i);
      if (s == 0) begin src0_q.push_back(bt); mdl0_q.push_back(bt); end
      else        begin src1_q.push_back(bt); mdl1_q.push_back(bt); end
    end
  endtask

  // Predicts the full output schedule of one frame from its arbitration cycle.
  task automatic model_arb(input int c, input int s0_start, output int nxt);
    bit         e0, e1;
    int         own, p, n, len, gap, k;
    beat_t      fr[$];
    beat_t      bt;
    obs_t       o;
    logic [1:0] g;
    e0 = (mdl0_q.size() > 0) && (c >= s0_start);
    e1 = (mdl1_q.size() > 0);
    if (!e0 && !e1) begin
      o = '0;
      exp_q.push_back(o);
      nxt = c + 1;
      return;
    end
    own = (e0 && e1) ? int'(rr_m[sel]) : (e0 ? 0 : 1);
    while (1) begin
      bt = (own == 0) ? mdl0_q.pop_front() : mdl1_q.pop_front();
      fr.push_back(bt);
      if (!bt.bub && bt.last) break;
    end
    p   = single_lane ? 8 : 2;
    n   = fr.size();
    gap = (sel == 0) ? 4 : 0;
    g   = (own == 0) ? 2'b01 : 2'b10;
    len = 2 + n * p + gap;
    for (int i = 0; i < len; i++) begin
      o = '0;
      if (i > 0) o.b = 1'b1;
      if (i >= 1 && i <= 1 + n * p) o.g = g;
      if (i >= 1 && i <= 1 + (n - 1) * p && (i - 1) % p == 0) o.r = g;
      if (i >= 2 && i < 2 + n * p) begin
        k = (i - 2) / p;
        if (!fr[k].bub) begin
          o.v = 1'b1;
          o.l = fr[k].last;
          o.d = fr[k].data;
        end
      end
      exp_q.push_back(o);
    end
    rr_m[sel] = (own == 0);
    nxt = c + len;
  endtask

  task automatic run_engine(input string name, input int max_cyc, input int s0_start,
                            input int lane_pol, input logic lane_fix, input bit partial);
    int   c, nxt, pend;
    obs_t e, a;
    logic rd0, rd1;
    c = 0; nxt = 0; pend = -1;
    exp_q.delete();
    while (1) begin
      if (src0_q.size() > 0 && c >= s0_start && !src0_q[0].bub) begin
        vld[0] = 1'b1; lst[0] = src0_q[0].last; dat[0] = src0_q[0].data;
      end else begin
        vld[0] = 1'b0; lst[0] = 1'($urandom); dat[0] = {$urandom, $urandom};
      end
      if (src1_q.size() > 0 && !src1_q[0].bub) begin
        vld[1] = 1'b1; lst[1] = src1_q[0].last; dat[1] = src1_q[0].data;
      end else begin
        vld[1] = 1'b0; lst[1] = 1'($urandom); dat[1] = {$urandom, $urandom};
      end
      case (lane_pol)
        1:       single_lane = 1'($urandom);
        2:       single_lane = (c == nxt) ? lane_fix : 1'($urandom);
        default: ;
      endcase
      @(negedge clk);
      if (c == nxt) begin
        model_arb(c, s0_start, nxt);
        if (nxt > c + 1) pend = c + 1;
      end
      a = sample();
      e = exp_q.pop_front();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s cyc=%0d got v=%0b l=%0b d=%h g=%b rdy=%b busy=%0b exp v=%0b l=%0b d=%h g=%b rdy=%b busy=%0b",
                 name, c, a.v, a.l, a.d, a.g, a.r, a.b, e.v, e.l, e.d, e.g, e.r, e.b);
      end
      if (a.v) vcnt++;
      if (c == pend) gseq.push_back(a.g);
      rd0 = r0_o[sel];
      rd1 = r1_o[sel];
      c++;
      @(posedge clk);
      #1;
      if (rd0 && src0_q.size() > 0) void'(src0_q.pop_front());
      if (rd1 && src1_q.size() > 0) void'(src1_q.pop_front());
      if (!partial && exp_q.size() == 0 && c == nxt && mdl0_q.size() == 0 && mdl1_q.size() == 0) break;
      if (c >= max_cyc) begin
        if (!partial) begin
          total++; bad++;
          $display("FAIL %s timeout got cycles=%0d required frames drained", name, c);
        end
        break;
      end
    end
    vld = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sel = 0;
    vld = 2'b11;
    dat[0] = '1; dat[1] = '1;
    #12;
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({mv_o[k], ml_o[k], md_o[k], g_o[k], b_o[k], r0_o[k], r1_o[k]} !== '0) begin
        bad++;
        $display("FAIL reset_state inst=%0d got v=%0b l=%0b d=%h g=%b busy=%0b rdy=%b%b required all zero",
                 k, mv_o[k], ml_o[k], md_o[k], g_o[k], b_o[k], r1_o[k], r0_o[k]);
      end
    end
    vld = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_gseq(input string name, input logic [1:0] req [$]);
    total++;
    if (gseq.size() != req.size()) begin
      bad++;
      $display("FAIL %s grant_count got=%0d required=%0d", name, gseq.size(), req.size());
    end
    for (int i = 0; i < req.size() && i < gseq.size(); i++) begin
      total++;
      if (gseq[i] !== req[i]) begin
        bad++;
        $display("FAIL %s grant[%0d] got=%b required=%b", name, i, gseq[i], req[i]);
      end
    end
  endtask

  task automatic check_vcnt(input string name, input int req);
    total++;
    if (vcnt !== req) begin
      bad++;
      $display("FAIL %s valid_cycles got=%0d required=%0d", name, vcnt, req);
    end
  endtask

  task automatic test_round_robin();
    sel = 0; single_lane = 1'b0; gseq.delete(); vcnt = 0;
    for (int i = 0; i < 3; i++) begin
      add_frame(0, 2, W'(64'h100 + 64'h10 * i), -1, 0);
      add_frame(1, 2, W'(64'h200 + 64'h10 * i), -1, 0);
    end
    run_engine("round_robin", 500, 0, 0, 1'b0, 0);
    check_gseq("round_robin", '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10});
    check_vcnt("round_robin", 24);
  endtask

  task automatic test_basic_frame();
    sel = 0; single_lane = 1'b0; vcnt = 0;
    add_frame(0, 3, W'(64'hA1), -1, 0);
    run_engine("basic_frame", 200, 0, 0, 1'b0, 0);
    check_vcnt("basic_frame", 6);
  endtask

  task automatic test_single_lane();
    sel = 0; vcnt = 0;
    add_frame(0, 3, W'(64'hA1), -1, 0);
    run_engine("single_lane", 300, 0, 2, 1'b1, 0);
    check_vcnt("single_lane", 24);
  endtask

  task automatic test_bubble();
    sel = 0; single_lane = 1'b0; gseq.delete(); vcnt = 0;
    add_frame(1, 3, W'(64'hB1), 1, 0);
    add_frame(0, 2, W'(64'hC1), -1, 0);
    run_engine("bubble", 300, 3, 0, 1'b0, 0);
    check_gseq("bubble", '{2'b10, 2'b01});
    check_vcnt("bubble", 10);
  endtask

  task automatic test_gap0();
    sel = 1; single_lane = 1'b0; vcnt = 0;
    add_frame(0, 2, W'(64'hD1), -1, 0);
    add_frame(0, 3, W'(64'hE1), -1, 0);
    run_engine("gap0", 300, 0, 0, 1'b0, 0);
    check_vcnt("gap0", 10);
  endtask

  task automatic test_random();
    int n, b;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int f = 0; f < 6; f++) begin
        for (int src = 0; src < 2; src++) begin
          n = $urandom_range(1, 4);
          b = (n >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : -1;
          add_frame(src, n, '0, b, 1);
        end
      end
      run_engine(s == 0 ? "random_gap4" : "random_gap0", 3000, 0, 1, 1'b0, 0);
    end
  endtask

  task automatic test_reset_mid();
    sel = 0; single_lane = 1'b0; gseq.delete();
    add_frame(0, 3, W'(64'hA1), -1, 0);
    run_engine("reset_mid_pre", 4, 0, 0, 1'b0, 1);
    total++;
    if (mv_o[0] !== 1'b1 || md_o[0] !== W'(64'hA2)) begin
      bad++;
      $display("FAIL reset_mid_beat2 got v=%0b d=%h required v=1 d=%h", mv_o[0], md_o[0], W'(64'hA2));
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({mv_o[0], ml_o[0], md_o[0], g_o[0], b_o[0], r0_o[0], r1_o[0]} !== '0) begin
      bad++;
      $display("FAIL reset_mid_async got v=%0b l=%0b d=%h g=%b busy=%0b required all zero",
               mv_o[0], ml_o[0], md_o[0], g_o[0], b_o[0]);
    end
    src0_q.delete(); src1_q.delete(); mdl0_q.delete(); mdl1_q.delete(); exp_q.delete();
    rr_m = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    gseq.delete();
    add_frame(1, 2, W'(64'hF1), -1, 0);
    add_frame(0, 2, W'(64'hF5), -1, 0);
    run_engine("reset_mid_post", 300, 0, 0, 1'b0, 0);
    check_gseq("reset_mid_post", '{2'b01, 2'b10});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got time=%0t required completion", $time);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    dat[0] = '0;
    dat[1] = '0;
    test_reset();
    test_round_robin();
    test_basic_frame();
    test_single_lane();
    test_bubble();
    test_gap0();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_frame_arbiter.md
# tx_frame_arbiter

Frame-granular round-robin arbiter that shares the single AXI-stream input of the Aurora TX data controller between two user sources. It locks onto one source for a whole frame, paces beats to the controller's consumption rate (one word per 8 cycles single-lane, per 2 cycles dual-lane), and inserts an idle gap between frames to cover end/start ordered sets. Sits between the user TX interfaces and the data controller.

## Interface
- DATA_W, default AXI_DATA_SIZE (aurora_pkg): word width.
- FRAME_GAP, default 4: idle cycles forced after each frame's last beat; 0 allowed.

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- single_lane  in  1  lane mode; sampled only in IDLE
- s0_valid, s1_valid  in  1  source beat valid
- s0_last, s1_last  in  1  source last beat of frame
- s0_data, s1_data  in  DATA_W  source word
- s0_ready, s1_ready  out  1  source beat accepted (combinational)
- m_valid  out  1  to controller axi_valid (registered)
- m_last  out  1  to controller axi_last (registered)
- m_data  out  DATA_W  to controller axi_data (registered)
- grant  out  2  one-hot frame owner, 00 when none (registered)
- busy  out  1  high when state != IDLE

## Operation
- Beat period P = 8 if latched lane mode is single, else 2; latched on IDLE->LOAD.
- States: IDLE, LOAD, HOLD, GAP.
- IDLE: m_* = 0, grant = 00. If exactly one sN_valid, grant N; if both, grant rr_ptr. -> LOAD.
- LOAD (1 cycle): owner's s_ready = 1, other = 0.
  - owner valid: m_valid<=1, m_last<=s_last, m_data<=s_data.
  - owner not valid (mid-frame bubble): m_valid<=0, m_last<=0, m_data<=0; owner kept.
  - -> HOLD, cnt<=0.
- HOLD (P-1 cycles, cnt 0..P-2): m_* held. At cnt==P-2: if m_valid&m_last -> GAP, else -> LOAD.
- GAP: m_* <= 0, grant <= 00, rr_ptr <= other source than finished owner. Stays FRAME_GAP cycles then -> IDLE; FRAME_GAP=0 goes straight to IDLE.
- rr_ptr resets to 0 (s0 preferred). Updated only at frame end.
- single_lane changes outside IDLE ignored until next frame.
- Non-owner never sees ready; its valid/data may change freely.

## Timing
- Reset (async assert): state IDLE, m_valid/m_last/m_data 0, grant 00, busy 0, rr_ptr 0, cnt 0, s_ready 0. Mid-frame reset drops the frame; no partial beat emitted after deassert.
- s_valid seen in IDLE cycle t -> LOAD at t+1 (s_ready high) -> m_valid at t+2.
- Each beat held on m_* exactly P cycles; consecutive beats of one frame back-to-back with no m_* gap.
- After last beat's P cycles: FRAME_GAP cycles of m_valid=0, then 1 IDLE cycle, then LOAD: inter-frame distance = FRAME_GAP + 2 cycles of m_valid=0 minimum.
- s_ready is a single-cycle pulse per beat; handshake = s_ready & s_valid in LOAD.
- Simultaneous requests in IDLE: rr_ptr wins; loser keeps valid and wins next arbitration.

## Test plan
- Reset then s0 sends 3-beat frame (0xA1,0xA2,0xA3 last), single_lane=0 -> m_valid from cycle t+2, each word held 2 cycles, m_last only with 0xA3, grant=01 throughout, then 4 idle cycles.
- Same frame with single_lane=1 -> each word held 8 cycles; toggling single_lane mid-frame leaves P=8.
- s0 and s1 both valid continuously with 2-beat frames -> grants alternate 01,10,01,10; s0 first after reset.
- s1 owner drops valid for one LOAD mid-frame -> one P-cycle beat with m_valid=0, grant stays 10, remaining beats follow, s0 not served until s1's last beat done.
- FRAME_GAP=0 -> exactly 2 cycles m_valid=0 (GAP skipped, IDLE, LOAD) between frames.
- rst_n asserted during HOLD of beat 2 -> m_* and grant zero immediately (asynchronously); after release, new frame starts cleanly with s0 priority.
